// File: rtl/secuenciador_pc_pkg.sv
// Shared processor definitions: program-sequencer opcodes and ALU opcodes.
package secuenciador_pc_pkg;

  // Sequencer operations; encodings 6 and 7 behave as OP_NEXT.
  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } seq_op_e;

  // ALU operations used by the datapath next to the sequencer.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

endpackage

// File: rtl/secuenciador_pc_pila.sv
// Parameterised LIFO return stack: one push or one pop per cycle, guarded
// internally against overflow and underflow.
module pila_param #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [IW:0]   sp_q;
  logic [IW:0]   sp_d;
  logic          do_push;
  logic          do_pop;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign full    = (sp_q == (IW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign depth   = sp_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = sp_q[IW-1:0];
  assign top_idx = IW'(sp_q - 1'b1);
  assign dout    = mem_q[top_idx];

  // Next stack pointer: up on push, down on pop, else hold.
  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_q - 1'b1;
  end

  // Stack pointer register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Storage write on push.
  // NOTE: the array is deliberately not reset; entries at or above the
  // pointer are never read as valid, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/secuenciador_pc.sv
// Program counter sequencer with return stack and level interrupt entry.
module secuenciador_pc
  import secuenciador_pc_pkg::*;
#(
  parameter int          AW        = 10,
  parameter int          DEPTH     = 16,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned IRQ_VEC   = (2 ** AW) - 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             op,
  input  logic                   cond,
  input  logic [AW-1:0]          target,
  input  logic                   irq,
  input  logic                   irq_en,
  input  logic                   clr_err,
  output logic [AW-1:0]          pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   unf,
  output logic                   irq_ack
);

  logic [AW-1:0] pc_q, pc_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] st_din, st_dout;
  logic          st_push, st_pop;
  logic          ovf_set, unf_set;
  logic          irq_take;

  assign pc_inc   = pc_q + AW'(1);
  // A full stack blocks the interrupt; the level request simply stays pending.
  assign irq_take = irq && irq_en && !full;
  assign irq_ack  = irq_take && !reset;
  assign pc       = pc_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

  pila_param #(.W(AW), .DEPTH(DEPTH)) u_pila (
    .clk   (clk),
    .reset (reset),
    .push  (st_push),
    .pop   (st_pop),
    .din   (st_din),
    .dout  (st_dout),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Next-pc selection, stack control and error detection.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    st_din  = pc_inc;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (irq_take) begin
      // Push the current pc so the interrupted instruction re-executes.
      st_push = 1'b1;
      st_din  = pc_q;
      pc_d    = AW'(IRQ_VEC);
    end else begin
      case (op)
        OP_JUMP:   pc_d = cond ? target : pc_inc;
        OP_BRANCH: pc_d = cond ? (pc_q + target) : pc_inc;
        OP_CALL: begin
          if (!full) begin
            st_push = 1'b1;
            pc_d    = target;
          end else begin
            pc_d    = pc_inc;
            ovf_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            st_pop = 1'b1;
            pc_d   = st_dout;
          end else begin
            pc_d    = pc_inc;
            unf_set = 1'b1;
          end
        end
        OP_HOLD:   pc_d = pc_q;
        default:   pc_d = pc_inc;
      endcase
    end
    // A new error in the same cycle as clr_err wins.
    ovf_d = (ovf_q && !clr_err) || ovf_set;
    unf_d = (unf_q && !clr_err) || unf_set;
  end

  // PC and sticky error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= AW'(RESET_VEC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_pc.sv
// Directed self-checking bench for secuenciador_pc (AW=10, DEPTH=4).
module tb_secuenciador_pc;
  import secuenciador_pc_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] IRQ_V = 10'h3F0;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op;
  logic          cond;
  logic [AW-1:0] target;
  logic          irq, irq_en, clr_err;
  logic [AW-1:0] pc;
  logic [2:0]    depth;
  logic          full, empty, ovf, unf, irq_ack;

  int total = 0;
  int bad   = 0;

  secuenciador_pc #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC(0), .IRQ_VEC(1008)) dut (
    .clk(clk), .reset(reset), .op(op), .cond(cond), .target(target),
    .irq(irq), .irq_en(irq_en), .clr_err(clr_err), .pc(pc), .depth(depth),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // Caller is at a falling edge; drive, take one rising edge, return at the next falling edge.
  task automatic step(input logic [2:0] o, input logic c, input logic [AW-1:0] t);
    op = o; cond = c; target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; op = OP_HOLD; cond = 1'b0; target = '0;
    irq = 1'b0; irq_en = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 10'h000) begin bad++; $display("FAIL reset_pc: got=%h exp=000", pc); end
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL reset_depth: got=%0d exp=0", depth); end
    total++; if ({empty, full, ovf, unf, irq_ack} !== 5'b10000)
      begin bad++; $display("FAIL reset_flags: got e/f/o/u/a=%b exp=10000", {empty, full, ovf, unf, irq_ack}); end
  endtask

  task automatic test_next_hold();
    for (int i = 1; i <= 3; i++) begin
      step(OP_NEXT, 1'b0, '0);
      total++; if (pc !== AW'(i)) begin bad++; $display("FAIL next_%0d: got=%h exp=%h", i, pc, AW'(i)); end
    end
    step(OP_HOLD, 1'b0, '0);
    total++; if (pc !== 10'h003) begin bad++; $display("FAIL hold: got=%h exp=003", pc); end
    step(3'd7, 1'b1, 10'h055);
    total++; if (pc !== 10'h004) begin bad++; $display("FAIL op7_next: got=%h exp=004", pc); end
  endtask

  task automatic test_jump_branch();
    step(OP_JUMP, 1'b1, 10'h005);
    total++; if (pc !== 10'h005) begin bad++; $display("FAIL jump_taken: got=%h exp=005", pc); end
    step(OP_BRANCH, 1'b1, 10'h3FE);
    total++; if (pc !== 10'h003) begin bad++; $display("FAIL branch_back: got=%h exp=003", pc); end
    step(OP_JUMP, 1'b1, 10'h005);
    step(OP_BRANCH, 1'b0, 10'h3FE);
    total++; if (pc !== 10'h006) begin bad++; $display("FAIL branch_not: got=%h exp=006", pc); end
    step(OP_JUMP, 1'b0, 10'h100);
    total++; if (pc !== 10'h007) begin bad++; $display("FAIL jump_not: got=%h exp=007", pc); end
    step(OP_BRANCH, 1'b1, 10'h010);
    total++; if (pc !== 10'h017) begin bad++; $display("FAIL branch_fwd: got=%h exp=017", pc); end
    step(OP_JUMP, 1'b1, 10'h3FF);
    step(OP_NEXT, 1'b0, '0);
    total++; if (pc !== 10'h000) begin bad++; $display("FAIL next_wrap: got=%h exp=000", pc); end
  endtask

  task automatic test_call_ret();
    logic [AW-1:0] exp_pop [4];
    exp_pop[0] = 10'h101; exp_pop[1] = 10'h101; exp_pop[2] = 10'h101; exp_pop[3] = 10'h001;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(OP_CALL, 1'b0, 10'h100);
      total++; if (pc !== 10'h100 || depth !== 3'(i))
        begin bad++; $display("FAIL call_%0d: pc=%h depth=%0d exp pc=100 depth=%0d", i, pc, depth, i); end
    end
    total++; if (full !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL full_flag: full=%b ovf=%b exp 1 0", full, ovf); end
    step(OP_CALL, 1'b0, 10'h100);
    total++; if (pc !== 10'h101 || depth !== 3'd4 || ovf !== 1'b1)
      begin bad++; $display("FAIL call_overflow: pc=%h depth=%0d ovf=%b exp 101 4 1", pc, depth, ovf); end
    for (int i = 0; i < 4; i++) begin
      step(OP_RET, 1'b0, '0);
      total++; if (pc !== exp_pop[i] || depth !== 3'(3 - i))
        begin bad++; $display("FAIL ret_%0d: pc=%h depth=%0d exp pc=%h depth=%0d", i, pc, depth, exp_pop[i], 3 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_flag: got=%b exp=1", empty); end
    step(OP_RET, 1'b0, '0);
    total++; if (pc !== 10'h002 || depth !== 3'd0 || unf !== 1'b1)
      begin bad++; $display("FAIL ret_underflow: pc=%h depth=%0d unf=%b exp 002 0 1", pc, depth, unf); end
    clr_err = 1'b1;
    step(OP_NEXT, 1'b0, '0);
    total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL clr_err: ovf=%b unf=%b exp 0 0", ovf, unf); end
    step(OP_RET, 1'b0, '0);
    total++; if (unf !== 1'b1 || pc !== 10'h004)
      begin bad++; $display("FAIL clr_set_wins: unf=%b pc=%h exp 1 004", unf, pc); end
    clr_err = 1'b0;
    step(OP_NEXT, 1'b0, '0);
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_sticky: got=%b exp=1", unf); end
  endtask

  task automatic test_irq();
    do_reset();
    step(OP_JUMP, 1'b1, 10'h020);
    op = OP_JUMP; cond = 1'b1; target = 10'h055; irq = 1'b1; irq_en = 1'b1;
    #1;
    total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irq_ack_pulse: got=%b exp=1", irq_ack); end
    step(OP_JUMP, 1'b1, 10'h055);
    irq = 1'b0;
    #1;
    total++; if (pc !== IRQ_V || depth !== 3'd1 || irq_ack !== 1'b0)
      begin bad++; $display("FAIL irq_entry: pc=%h depth=%0d ack=%b exp 3f0 1 0", pc, depth, irq_ack); end
    step(OP_RET, 1'b0, '0);
    total++; if (pc !== 10'h020 || depth !== 3'd0)
      begin bad++; $display("FAIL irq_return: pc=%h depth=%0d exp 020 0", pc, depth); end
    irq = 1'b1; irq_en = 1'b0;
    step(OP_NEXT, 1'b0, '0);
    total++; if (pc !== 10'h021 || irq_ack !== 1'b0)
      begin bad++; $display("FAIL irq_masked: pc=%h ack=%b exp 021 0", pc, irq_ack); end
    irq = 1'b0;
  endtask

  task automatic test_irq_full();
    do_reset();
    for (int i = 0; i < 4; i++) step(OP_CALL, 1'b0, 10'h100);
    irq = 1'b1; irq_en = 1'b1; op = OP_NEXT;
    #1;
    total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irq_full_ack: got=%b exp=0", irq_ack); end
    step(OP_NEXT, 1'b0, '0);
    total++; if (pc !== 10'h101 || ovf !== 1'b0 || depth !== 3'd4)
      begin bad++; $display("FAIL irq_full_op: pc=%h ovf=%b depth=%0d exp 101 0 4", pc, ovf, depth); end
    step(OP_RET, 1'b0, '0);
    total++; if (pc !== 10'h101 || depth !== 3'd3)
      begin bad++; $display("FAIL irq_full_ret: pc=%h depth=%0d exp 101 3", pc, depth); end
    op = OP_NEXT;
    #1;
    total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irq_pending_ack: got=%b exp=1", irq_ack); end
    step(OP_NEXT, 1'b0, '0);
    total++; if (pc !== IRQ_V || depth !== 3'd4)
      begin bad++; $display("FAIL irq_pending_take: pc=%h depth=%0d exp 3f0 4", pc, depth); end
    irq = 1'b0;
    step(OP_RET, 1'b0, '0);
    total++; if (pc !== 10'h101) begin bad++; $display("FAIL irq_pending_ret: got=%h exp=101", pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(OP_NEXT, 1'b0, '0);
    step(OP_CALL, 1'b0, 10'h080);
    total++; if (pc !== 10'h080 || depth !== 3'd1)
      begin bad++; $display("FAIL pre_reset_call: pc=%h depth=%0d exp 080 1", pc, depth); end
    #2 reset = 1'b1;
    #1;
    total++; if (pc !== 10'h000 || depth !== 3'd0 || empty !== 1'b1 || irq_ack !== 1'b0)
      begin bad++; $display("FAIL async_reset: pc=%h depth=%0d empty=%b ack=%b exp 000 0 1 0", pc, depth, empty, irq_ack); end
    @(negedge clk);
    reset = 1'b0;
    step(OP_JUMP, 1'b1, 10'h033);
    total++; if (pc !== 10'h033) begin bad++; $display("FAIL first_edge_op: got=%h exp=033", pc); end
  endtask

  initial begin
    reset = 1'b1; op = OP_HOLD; cond = 1'b0; target = '0;
    irq = 1'b0; irq_en = 1'b0; clr_err = 1'b0;
    test_reset();
    test_next_hold();
    test_jump_branch();
    test_call_ret();
    test_irq();
    test_irq_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_pc.md
SECUENCIADOR_PC -- requirements
Module: secuenciador_pc

Interface
REQ-001 SHALL have parameter AW, default 10, meaning program-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, meaning PC value after reset.
REQ-004 SHALL have parameter IRQ_VEC, default 2^AW-16, meaning interrupt target address.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port op  input  3  operation: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6-7 treated as NEXT.
REQ-008 SHALL have port cond  input  1  condition gating JUMP/BRANCH (e.g. ALU zero flag); 1 = taken.
REQ-009 SHALL have port target  input  AW  absolute address for JUMP/CALL; two's-complement offset for BRANCH.
REQ-010 SHALL have port irq  input  1  level interrupt request.
REQ-011 SHALL have port irq_en  input  1  interrupt enable.
REQ-012 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-013 SHALL have port pc  output  AW  current program address (registered).
REQ-014 SHALL have port depth  output  $clog2(DEPTH)+1  occupied return-stack entries.
REQ-015 SHALL have ports full, empty  output  1 each  depth==DEPTH, depth==0.
REQ-016 SHALL have ports ovf, unf  output  1 each  sticky overflow / underflow flags.
REQ-017 SHALL have port irq_ack  output  1  one-cycle pulse in the cycle an interrupt is taken.

Function
REQ-018 NEXT SHALL load pc+1 (mod 2^AW).
REQ-019 JUMP SHALL load target if cond=1, else pc+1.
REQ-020 BRANCH SHALL load pc+target (mod 2^AW, wrap-around) if cond=1, else pc+1.
REQ-021 CALL SHALL push pc+1 and load target when not full.
REQ-022 CALL when full SHALL not push, SHALL load pc+1, SHALL set ovf.
REQ-023 RET SHALL pop the top entry into pc when not empty.
REQ-024 RET when empty SHALL load pc+1, SHALL set unf, depth stays 0.
REQ-025 HOLD SHALL keep pc and stack unchanged.
REQ-026 Interrupt SHALL be taken when irq=1, irq_en=1, not full; it SHALL override op, push pc (instruction at pc re-executes on return), load IRQ_VEC, assert irq_ack for that cycle.
REQ-027 irq with stack full SHALL NOT be taken, SHALL NOT set ovf; op executes normally and request remains pending (level).
REQ-028 At most one push or pop SHALL occur per cycle; depth changes by exactly +1, -1 or 0.
REQ-029 clr_err SHALL clear ovf/unf; if a new error occurs in the same cycle, the flag SHALL be set (set wins).
REQ-030 full, empty, depth SHALL be combinational functions of the registered stack pointer.
REQ-031 Stack storage SHALL be a register array; entries above depth are don't-care.
REQ-032 pc update latency SHALL be one clock: op sampled at edge n appears on pc after edge n.

Reset
REQ-033 Asserting reset at any time, including mid-CALL/RET, SHALL immediately force pc=RESET_VEC, depth=0, empty=1, full=0, ovf=0, unf=0, irq_ack=0.
REQ-034 Stack contents SHALL NOT require reset.
REQ-035 First edge after reset deassertion SHALL execute the op presented then.

Structure
REQ-036 Opcode constants (NEXT..HOLD) SHALL live in the shared processor package alongside the ALU op codes.
REQ-037 The return stack SHALL be a sub-module pila_param (parameters W, DEPTH; ports push, pop, din, dout, depth, full, empty); sequencing logic stays in secuenciador_pc.
REQ-038 Implementation SHALL reuse existing sum/mux2 cells or equivalent inline arithmetic; no latches.

Verification
REQ-039 Reset, NEXT x3 -> pc 0,1,2,3; HOLD -> pc stays 3.
REQ-040 pc=5, BRANCH target=10'h3FE cond=1 -> pc=3; cond=0 -> pc=6; pc=10'h3FF NEXT -> pc=0.
REQ-041 DEPTH=4: CALL to 0x100 x4 from pc 0 -> depth 4, full=1; 5th CALL -> no push, ovf=1, pc+1; RET x4 -> pops 0x101,0x101,0x101,1 in order; extra RET -> unf=1, pc+1.
REQ-042 irq=1 irq_en=1 at pc=0x20 with op=JUMP -> pc=IRQ_VEC, irq_ack pulse, depth+1; RET -> pc=0x20.
REQ-043 Stack full with irq=1 -> irq_ack=0, ovf stays 0, op executes; after RET irq taken next cycle.
REQ-044 Assert reset asynchronously between edges after CALL -> pc=RESET_VEC and depth=0 before next edge; clr_err with simultaneous underflow -> unf=1.
